// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned FETCH_W     = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    KILL
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_W-1:0] pc;
    logic [FETCH_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetched-instruction buffer: synchronous FIFO of {pc, inst} with flush and
// registered head outputs so decode sees flop-driven signals.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output fetch_entry_t           head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_kept;
  logic             push_en;
  logic             pop_en;
  fetch_entry_t     head_d;

  // Flush beats both push and pop; a push into an empty FIFO bypasses to the head.
  always_comb begin
    push_en    = push && !flush;
    pop_en     = pop && (count != '0) && !flush;
    count_kept = count - CNT_W'(pop_en);
    rd_ptr_d   = rd_ptr + PTR_W'(pop_en);
    wr_ptr_d   = wr_ptr + PTR_W'(push_en);
    count_d    = count_kept + CNT_W'(push_en);
    head_d     = '0;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (count_d != '0) begin
      head_d = (count_kept == '0) ? push_data : mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else begin
      rd_ptr     <= rd_ptr_d;
      wr_ptr     <= wr_ptr_d;
      count      <= count_d;
      head_valid <= (count_d != '0);
      head       <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// PC register, single-outstanding imem read FSM and fetch buffer feeding decode.
// Optional MISALIGN_TRAP_EN adds a sticky fetch_fault on unaligned redirect targets.
module pc_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned      FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PCsrc,
  input  logic [WIDTH-1:0] branch_base,
  input  logic [WIDTH-1:0] ImmOp,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             inst_ready
`ifdef MISALIGN_TRAP_EN
  ,
  output logic             fetch_fault
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t     state_q;
  fetch_state_t     state_d;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] target_raw;
  logic [WIDTH-1:0] target;
  logic             push;
  logic             pop;
  logic             flush;
  logic             fault_d;
  logic             can_issue;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  // Next-state, next-PC and buffer control; issue only if the slot is free after this edge.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush      = PCsrc;
    push       = (state_q == ISSUE) && imem_ack && !PCsrc;
    pop        = inst_valid && inst_ready;
    target_raw = branch_base + ImmOp;
    target     = target_raw & ~WIDTH'(INSTR_BYTES - 1);
    fault_d    = 1'b0;
`ifdef MISALIGN_TRAP_EN
    fault_d    = fetch_fault || (PCsrc && ((target_raw & WIDTH'(INSTR_BYTES - 1)) != '0));
`endif
    count_after = flush ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
    can_issue   = !fault_d && (count_after < CNT_W'(FIFO_DEPTH));

    if (PCsrc) begin
      pc_d = target;
    end else if (push) begin
      pc_d = pc_q + WIDTH'(INSTR_BYTES);
    end

    case (state_q)
      IDLE: begin
        if (can_issue) state_d = ISSUE;
      end
      ISSUE: begin
        if (imem_ack) begin
          state_d = can_issue ? ISSUE : IDLE;
        end else if (PCsrc) begin
          state_d = KILL;
        end
      end
      KILL: begin
        if (imem_ack) state_d = can_issue ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The address is frozen while a killed read drains so the memory sees a stable request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      imem_req <= (state_d != IDLE);
      if (state_d != KILL) begin
        imem_addr <= pc_d;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_fault <= 1'b0;
    end else begin
      fetch_fault <= fault_d;
    end
  end
`endif

  always_comb begin
    push_entry      = '0;
    push_entry.pc   = FETCH_W'(pc_q);
    push_entry.inst = FETCH_W'(imem_rdata);
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .flush      (flush),
    .count      (count),
    .head_valid (inst_valid),
    .head       (head)
  );

  assign inst    = WIDTH'(head.inst);
  assign inst_pc = WIDTH'(head.pc);

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with a configurable-latency instruction memory.
`timescale 1ns/1ps
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCsrc;
  logic [31:0] branch_base;
  logic [31:0] ImmOp;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
`ifdef MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  logic zero_wait = 1'b1;
  logic ack_lat   = 1'b0;
  int   lat       = 3;
  int   wcnt      = 0;
  int   total     = 0;
  int   bad       = 0;

  always #5 clk = ~clk;

  pc_fetch #(
    .WIDTH      (32),
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCsrc       (PCsrc),
    .branch_base (branch_base),
    .ImmOp       (ImmOp),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
`ifdef MISALIGN_TRAP_EN
    ,
    .fetch_fault (fetch_fault)
`endif
  );

  assign imem_ack   = zero_wait ? imem_req : ack_lat;
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  // Slow memory: ack lands in the lat-th cycle of each request.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack_lat = 1'b0;
        wcnt    = 0;
      end else begin
        if (ack_lat) begin
          ack_lat = 1'b0;
          wcnt    = 0;
        end
        if (!zero_wait && imem_req) begin
          wcnt = wcnt + 1;
          if (wcnt >= lat) ack_lat = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    PCsrc       = 1'b0;
    branch_base = '0;
    ImmOp       = '0;
    inst_ready  = 1'b1;
    zero_wait   = 1'b1;
    rst_n       = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    reset_release();
`ifdef MISALIGN_TRAP_EN
    check("rst_fault", 32'(fetch_fault), 32'h0);
`endif

    // Zero-wait streaming: one fetch per cycle, inst_pc one cycle behind imem_addr.
    tick();
    check("zw_req0", 32'(imem_req), 32'h1);
    check("zw_addr0", imem_addr, 32'h0);
    check("zw_valid0", 32'(inst_valid), 32'h0);
    tick();
    check("zw_addr1", imem_addr, 32'h4);
    check("zw_valid1", 32'(inst_valid), 32'h1);
    check("zw_pc1", inst_pc, 32'h0);
    check("zw_inst1", inst, 32'hDEAD_0000);
    tick();
    check("zw_addr2", imem_addr, 32'h8);
    check("zw_pc2", inst_pc, 32'h4);
    tick();
    check("zw_addr3", imem_addr, 32'hC);
    check("zw_pc3", inst_pc, 32'h8);

    // Async reset mid-transaction, no clock edge needed.
    rst_n      = 1'b0;
    inst_ready = 1'b0;
    #1;
    check("arst_req", 32'(imem_req), 32'h0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_valid", 32'(inst_valid), 32'h0);
    reset_release();

    // Stalled decode: two fetches fill the buffer, then requests stop.
    tick(2);
    check("full_addr1", imem_addr, 32'h4);
    check("full_pc0", inst_pc, 32'h0);
    tick();
    check("full_req_off", 32'(imem_req), 32'h0);
    check("full_valid", 32'(inst_valid), 32'h1);
    check("full_head", inst_pc, 32'h0);
    tick();
    check("full_req_hold", 32'(imem_req), 32'h0);
    inst_ready = 1'b1;
    tick();
    check("resume_req", 32'(imem_req), 32'h1);
    check("resume_addr", imem_addr, 32'h8);
    check("resume_head", inst_pc, 32'h4);
    inst_ready = 1'b0;
    tick();
    check("refill_req_off", 32'(imem_req), 32'h0);
    check("refill_head", inst_pc, 32'h4);

    // Redirect with a full buffer: 0x10 + (-8) = 0x08.
    PCsrc       = 1'b1;
    branch_base = 32'h10;
    ImmOp       = 32'hFFFF_FFF8;
    tick();
    PCsrc = 1'b0;
    check("redir_flush", 32'(inst_valid), 32'h0);
    check("redir_req", 32'(imem_req), 32'h1);
    check("redir_addr", imem_addr, 32'h8);
    tick();
    check("redir_valid", 32'(inst_valid), 32'h1);
    check("redir_pc", inst_pc, 32'h8);
    check("redir_inst", inst, 32'hDEAD_0008);

    // Three-cycle memory; redirect to 0x40 in the first cycle of the read at 0x4.
    rst_n     = 1'b0;
    zero_wait = 1'b0;
    lat       = 3;
    reset_release();
    tick();
    check("slow_addr0", imem_addr, 32'h0);
    tick(3);
    check("slow_addr1", imem_addr, 32'h4);
    check("slow_valid0", 32'(inst_valid), 32'h1);
    check("slow_pc0", inst_pc, 32'h0);
    PCsrc       = 1'b1;
    branch_base = 32'h30;
    ImmOp       = 32'h10;
    tick();
    PCsrc = 1'b0;
    check("kill_req", 32'(imem_req), 32'h1);
    check("kill_addr_a", imem_addr, 32'h4);
    check("kill_flush", 32'(inst_valid), 32'h0);
    tick();
    check("kill_addr_b", imem_addr, 32'h4);
    tick();
    check("kill_target", imem_addr, 32'h40);
    check("kill_nopush", 32'(inst_valid), 32'h0);
    tick(3);
    check("kill_fetch_valid", 32'(inst_valid), 32'h1);
    check("kill_fetch_pc", inst_pc, 32'h40);

    // Wrap at the top of the address space; redirect coinciding with ack and with pop.
    rst_n      = 1'b0;
    zero_wait  = 1'b1;
    inst_ready = 1'b1;
    reset_release();
    tick();
    PCsrc       = 1'b1;
    branch_base = 32'hFFFF_FFF0;
    ImmOp       = 32'hC;
    tick();
    PCsrc = 1'b0;
    check("ackredir_addr", imem_addr, 32'hFFFF_FFFC);
    check("ackredir_drop", 32'(inst_valid), 32'h0);
    tick();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_inst", inst, 32'h2152_FFFC);
    PCsrc       = 1'b1;
    branch_base = 32'h100;
    ImmOp       = 32'h0;
    tick();
    PCsrc = 1'b0;
    check("popredir_valid", 32'(inst_valid), 32'h0);
    check("popredir_addr", imem_addr, 32'h100);
    tick();
    check("popredir_pc0", inst_pc, 32'h100);
    check("popredir_addr1", imem_addr, 32'h104);
    tick();
    check("popredir_v1", 32'(inst_valid), 32'h1);
    check("popredir_pc1", inst_pc, 32'h104);

    // Unaligned target 0x22 while a slow read is outstanding.
    rst_n      = 1'b0;
    zero_wait  = 1'b0;
    lat        = 3;
    inst_ready = 1'b0;
    reset_release();
    tick();
    PCsrc       = 1'b1;
    branch_base = 32'h20;
    ImmOp       = 32'h2;
    tick();
    PCsrc = 1'b0;
    check("mis_hold_req", 32'(imem_req), 32'h1);
    check("mis_hold_addr", imem_addr, 32'h0);
`ifdef MISALIGN_TRAP_EN
    check("mis_fault", 32'(fetch_fault), 32'h1);
    tick(2);
    check("mis_stop_req", 32'(imem_req), 32'h0);
    check("mis_fault_sticky", 32'(fetch_fault), 32'h1);
    tick(3);
    check("mis_still_stop", 32'(imem_req), 32'h0);
    check("mis_no_valid", 32'(inst_valid), 32'h0);
`else
    tick(2);
    check("mis_req", 32'(imem_req), 32'h1);
    check("mis_align_addr", imem_addr, 32'h20);
    tick(3);
    check("mis_fetch_pc", inst_pc, 32'h20);
    check("mis_next_addr", imem_addr, 32'h24);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
Consumes the next-PC decision (branch flag plus immediate offset) and owns the architectural PC register. It issues instruction-memory reads over a req/ack handshake and buffers fetched instructions in a small FIFO. It presents the instructions to decode over a valid/ready interface. It sits between the execute-stage branch logic and the decode stage of the RISC-V core.

Parameters:
- WIDTH, 32, address/data width in bits.
- RESET_PC, 32'h0, first fetch address after reset.
- FIFO_DEPTH, 2, fetched-instruction buffer entries (power of two, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- PCsrc  in  1  branch-taken redirect strobe, one cycle.
- branch_base  in  WIDTH  PC of the branching instruction.
- ImmOp  in  WIDTH  sign-extended branch offset.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  WIDTH  read address, stable while imem_req is high.
- imem_ack  in  1  read complete; imem_rdata valid this cycle.
- imem_rdata  in  WIDTH  instruction word.
- inst_valid  out  1  FIFO head valid.
- inst  out  WIDTH  head instruction.
- inst_pc  out  WIDTH  head instruction address.
- inst_ready  in  1  decode accepts head.

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, FIFO empty, inst_valid=0, inst=0, inst_pc=0, state=IDLE.
- FSM states: IDLE, ISSUE, KILL.
- IDLE -> ISSUE on the first clock edge after rst_n rises, or whenever free slots > 0 (free = DEPTH − count − outstanding).
- ISSUE: imem_req=1 and imem_addr=PC, held until imem_ack is sampled high.
- On ack: push {PC, imem_rdata}, PC <= PC+4 (modulo 2^WIDTH; 32'hFFFFFFFC wraps to 0). Then go to ISSUE again if a slot is free, otherwise IDLE.
- At most one outstanding request. A request is never raised when the FIFO plus the outstanding read would exceed FIFO_DEPTH.
- Ack in the same cycle as req is legal (zero-wait memory) and yields one fetch per cycle.
- Redirect: target = branch_base + ImmOp, with WIDTH-bit wrap and carry discarded.
  - PCsrc flushes the FIFO in the same edge and sets PC <= target.
  - If a request is outstanding and unacked, go to KILL: req stays high with the old address until ack, and the data is discarded. Then go to ISSUE at target.
  - If PCsrc coincides with ack: the acked data is discarded, no push, and the next cycle issues target.
  - If PCsrc coincides with inst_ready && inst_valid: the flush wins and nothing is double-counted.
  - If PCsrc arrives while in KILL: the target is updated to the newest value and KILL continues.
- Output side: inst_valid = count≠0. A pop occurs when inst_valid && inst_ready. Push and pop in the same cycle keep count unchanged. Latency is ack edge -> inst_valid high in the next cycle.
- Target bits [1:0] are cleared (word-aligned), except as stated under Optional Feature.
- rst_n asserted mid-transaction: all state returns to reset values immediately. A pending ack is ignored.

Optional Feature:
MISALIGN_TRAP_EN.
- Defined: adds output fetch_fault (1 bit, reset 0). A redirect target with bits[1:0]≠0 sets fetch_fault=1 (sticky until reset), flushes the FIFO, and stops issuing requests. Any outstanding request still completes and is discarded.
- Undefined: no extra port; the low two target bits are silently cleared.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {IDLE, ISSUE, KILL};
  - fetch_entry_t struct {pc, inst};
  - constant INSTR_BYTES=4.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, and registered head outputs.

Test Plan:
- Reset release, zero-wait memory (ack=req), inst_ready=1 -> imem_addr 0,4,8,C on consecutive cycles; inst_pc trails by one cycle.
- inst_ready=0, ack=req -> exactly 2 fetches (0,4), then imem_req=0 and inst_valid=1 held. Raising ready resumes fetching at 8.
- PCsrc=1, branch_base=0x10, ImmOp=0xFFFFFFF8 while the FIFO holds 2 entries -> FIFO empties, and the next imem_addr is 0x08.
- Memory with 3-cycle ack latency; PCsrc (target 0x40) in cycle 1 of a read at 0x4 -> req holds addr 0x4 until ack, no push, next req at 0x40.
- PC=0xFFFFFFFC fetch acked -> next imem_addr=0x0.
- MISALIGN_TRAP_EN: target 0x22 -> fetch_fault=1, and no further imem_req after any outstanding ack. Without the macro: imem_addr=0x20.
